// File: rtl/run_ctrl_pkg.sv
// Shared run-control types and default sizing for the halt controller.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } run_state_t;

    typedef enum logic [1:0] {
        HR_NONE   = 2'd0,
        HR_INSTR  = 2'd1,
        HR_CYCLES = 2'd2,
        HR_STALL  = 2'd3
    } halt_reason_t;

    localparam int unsigned DEF_CNT_W       = 16;
    localparam int unsigned DEF_MAX_CYCLES  = 850;
    localparam int unsigned DEF_STALL_LIMIT = 64;
    localparam int unsigned DEF_DRAIN_MAX   = 16;

endpackage

// File: rtl/halt_controller_sat_counter.sv
// Saturating up-counter with synchronous clear and freeze (freeze wins over clear).
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    input  logic         i_freeze,
    output logic [W-1:0] o_count
);

    localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

    logic [W-1:0] r_count;

    // Count register: hold when frozen, clear on request, else increment until all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (!i_freeze) begin
            if (i_clr) begin
                r_count <= '0;
            end else if (i_inc && (r_count != MAX_VAL)) begin
                r_count <= r_count + W'(1);
            end
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/halt_controller.sv
// Run-control: drains stores after a retired halt, or forces halt on cycle/stall watchdogs.
module halt_controller
    import run_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned MAX_CYCLES  = DEF_MAX_CYCLES,
    parameter int unsigned STALL_LIMIT = DEF_STALL_LIMIT,
    parameter int unsigned DRAIN_MAX   = DEF_DRAIN_MAX
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             retire_valid,
    input  logic             retire_is_halt,
    input  logic             store_pending,
    output logic             halt,
    output logic [1:0]       halt_reason,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count,
    output logic             running
);

    localparam int unsigned    STALL_W = $clog2(STALL_LIMIT + 1);
    localparam int unsigned    DRAIN_W = $clog2(DRAIN_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // The cycle counter must be able to hold the watchdog threshold.
    if (64'(MAX_CYCLES) > ((64'(1) << CNT_W) - 64'(1))) begin : g_max_cycles_chk
        $error("halt_controller: MAX_CYCLES does not fit in CNT_W bits");
    end

    run_state_t       r_state;
    run_state_t       w_state_nxt;
    logic             r_halt;
    logic             w_halt_nxt;
    halt_reason_t     r_halt_reason;
    halt_reason_t     w_reason_nxt;
    logic             r_running;
    logic             w_running_nxt;
    logic [CNT_W-1:0] r_cycle_count;
    logic [CNT_W-1:0] w_cycle_nxt;

    logic [STALL_W-1:0] w_stall_count;
    logic [DRAIN_W-1:0] w_drain_count;

    logic w_in_run;
    logic w_in_drain;
    logic w_in_halted;
    logic w_halt_instr;
    logic w_cycle_limit;
    logic w_stall_limit;
    logic w_drain_timeout;

    assign w_in_run    = (r_state == RUN);
    assign w_in_drain  = (r_state == DRAIN);
    assign w_in_halted = (r_state == HALTED);

    // Halt-event qualifiers; retire_is_halt means nothing without retire_valid.
    assign w_halt_instr    = retire_valid && retire_is_halt;
    assign w_cycle_limit   = (r_cycle_count == CNT_W'(MAX_CYCLES - 1));
    assign w_stall_limit   = (w_stall_count == STALL_W'(STALL_LIMIT - 1)) && !retire_valid;
    assign w_drain_timeout = (w_drain_count == DRAIN_W'(DRAIN_MAX - 1));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: halt instruction beats cycle limit beats stall watchdog.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (w_halt_instr) begin
                    w_state_nxt = DRAIN;
                end else if (w_cycle_limit || w_stall_limit) begin
                    w_state_nxt = HALTED;
                end
            end
            DRAIN: begin
                if (!store_pending || w_drain_timeout) begin
                    w_state_nxt = HALTED;
                end
            end
            HALTED:  w_state_nxt = HALTED;
            default: w_state_nxt = RUN;
        endcase
    end

    // Output logic: next values for the registered status outputs.
    always_comb begin
        w_halt_nxt    = (w_state_nxt == HALTED);
        w_running_nxt = (w_state_nxt == RUN);
        w_reason_nxt  = r_halt_reason;
        w_cycle_nxt   = r_cycle_count;
        if (!w_in_halted && (r_cycle_count != CNT_MAX)) begin
            w_cycle_nxt = r_cycle_count + CNT_W'(1);
        end
        case (r_state)
            RUN: begin
                if (w_halt_instr) begin
                    w_reason_nxt = HR_INSTR;
                end else if (w_cycle_limit) begin
                    w_reason_nxt = HR_CYCLES;
                end else if (w_stall_limit) begin
                    w_reason_nxt = HR_STALL;
                end
            end
            DRAIN: begin
                if (store_pending && w_drain_timeout) begin
                    w_reason_nxt = HR_STALL;
                end
            end
            default: ;
        endcase
    end

    // Registered status outputs, updated on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halt        <= 1'b0;
            r_halt_reason <= HR_NONE;
            r_running     <= 1'b1;
            r_cycle_count <= '0;
        end else begin
            r_halt        <= w_halt_nxt;
            r_halt_reason <= w_reason_nxt;
            r_running     <= w_running_nxt;
            r_cycle_count <= w_cycle_nxt;
        end
    end

    // Retired-instruction counter; only RUN retires count.
    sat_counter #(.W(CNT_W)) u_instret (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (1'b0),
        .i_inc    (w_in_run && retire_valid),
        .i_freeze (!w_in_run),
        .o_count  (instret_count)
    );

    // Consecutive non-retiring RUN cycles.
    sat_counter #(.W(STALL_W)) u_stall (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (retire_valid),
        .i_inc    (!retire_valid),
        .i_freeze (!w_in_run),
        .o_count  (w_stall_count)
    );

    // Cycles spent waiting for stores; starts from zero on DRAIN entry.
    sat_counter #(.W(DRAIN_W)) u_drain (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_in_run),
        .i_inc    (w_in_drain),
        .i_freeze (w_in_halted),
        .o_count  (w_drain_count)
    );

    assign halt        = r_halt;
    assign halt_reason = r_halt_reason;
    assign cycle_count = r_cycle_count;
    assign running     = r_running;

endmodule
